// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU datapath memory interface.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF         = 9;
  localparam int unsigned DATA_W_DEF         = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mdr_reg.sv
// MDR register with its MDMux: loads either the bus or RAM read data.
module mdr_reg
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              load,
  input  logic              sel_mem,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      q <= '0;
    end else if (load) begin
      q <= sel_mem ? mem_rdata : bus_in;
    end
  end

endmodule

// File: rtl/mem_if_ctrl.sv
// Memory interface stage: MAR/MDR plus the RAM request/acknowledge sequencer.
// Optional wait timeout is enabled with the MEM_IF_TIMEOUT_EN macro.
module mem_if_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef MEM_IF_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mar_q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  mem_state_e state;
  logic       mdr_load;
  logic       mdr_sel_mem;

  // Bus loads only while idle; RAM data loads on the read acknowledge.
  assign mdr_sel_mem = (state == RD_WAIT);
  assign mdr_load    = ((state == IDLE) && mdr_in) || ((state == RD_WAIT) && mem_ack);

  mdr_reg #(.DATA_W(DATA_W)) u_mdr (
    .clk       (clk),
    .clear_n   (clear_n),
    .load      (mdr_load),
    .sel_mem   (mdr_sel_mem),
    .bus_in    (bus_in),
    .mem_rdata (mem_rdata),
    .q         (mdr_out)
  );

  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_out;

`ifdef MEM_IF_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state   <= IDLE;
      mar_q   <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
      err      <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef MEM_IF_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (mar_in) mar_q <= bus_in[ADDR_W-1:0];
          if (rd_req) begin
            state   <= RD_WAIT;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            busy    <= 1'b1;
          end else if (wr_req) begin
            state   <= WR_WAIT;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
`ifdef MEM_IF_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_if_ctrl.sv
// Directed self-checking bench for mem_if_ctrl (default and MEM_IF_TIMEOUT_EN builds).
module tb_mem_if_ctrl;

  logic        clk = 1'b0;
  logic        clear_n;
  logic [31:0] bus_in;
  logic        mar_in, mdr_in, rd_req, wr_req;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] mdr_out;
  logic [8:0]  mar_q;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_if_ctrl dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .bus_in    (bus_in),
    .mar_in    (mar_in),
    .mdr_in    (mdr_in),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mdr_out   (mdr_out),
    .mar_q     (mar_q),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_n = 1'b0; bus_in = '0; mar_in = 1'b0; mdr_in = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0; mem_rdata = '0; mem_ack = 1'b0;

    // Reset, then MAR load
    tick(); tick();
    check("rst_mar", 32'(mar_q), 32'h0);
    check("rst_mdr", mdr_out, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    clear_n = 1'b1; mar_in = 1'b1; bus_in = 32'h0000_0055;
    tick();
    mar_in = 1'b0;
    check("ld_mar", 32'(mar_q), 32'h055);
    check("ld_addr", 32'(mem_addr), 32'h055);
    check("ld_mdr", mdr_out, 32'h0);
    check("ld_busy", 32'(busy), 32'h0);

    // Stray ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_done", 32'(done), 32'h0);
    check("idle_ack_busy", 32'(busy), 32'h0);

    // Read, ack sampled on the third edge after the request
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("rd_req0", 32'(mem_req), 32'h1);
    check("rd_we", 32'(mem_we), 32'h0);
    check("rd_busy", 32'(busy), 32'h1);
    tick();
    check("rd_req1", 32'(mem_req), 32'h1);
    tick();
    check("rd_req2", 32'(mem_req), 32'h1);
    check("rd_nodone", 32'(done), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("rd_done", 32'(done), 32'h1);
    check("rd_mdr", mdr_out, 32'h1234_5678);
    check("rd_req_off", 32'(mem_req), 32'h0);
    check("rd_busy_done", 32'(busy), 32'h1);
    tick();
    check("rd_done_off", 32'(done), 32'h0);
    check("rd_idle", 32'(busy), 32'h0);

    // Write with MDR load in the request cycle, immediate ack
    mdr_in = 1'b1; bus_in = 32'hDEAD_BEEF; wr_req = 1'b1;
    tick();
    mdr_in = 1'b0; wr_req = 1'b0; bus_in = '0;
    check("wr_req", 32'(mem_req), 32'h1);
    check("wr_we", 32'(mem_we), 32'h1);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_addr", 32'(mem_addr), 32'h055);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("wr_done", 32'(done), 32'h1);
    check("wr_req_off", 32'(mem_req), 32'h0);
    check("wr_mdr_keep", mdr_out, 32'hDEAD_BEEF);
    tick();
    check("wr_done_off", 32'(done), 32'h0);
    check("wr_idle", 32'(busy), 32'h0);

    // Read beats write; busy-time loads and requests ignored
    rd_req = 1'b1; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check("pri_req", 32'(mem_req), 32'h1);
    check("pri_we", 32'(mem_we), 32'h0);
    mdr_in = 1'b1; mar_in = 1'b1; bus_in = 32'hFFFF_FFFF;
    tick();
    check("busy_mdr_frozen", mdr_out, 32'hDEAD_BEEF);
    check("busy_mar_frozen", 32'(mem_addr), 32'h055);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    tick();
    mem_ack = 1'b0; mem_rdata = '0; mdr_in = 1'b0; mar_in = 1'b0;
    check("busy_mdr_mem", mdr_out, 32'hA5A5_0001);
    check("busy_done", 32'(done), 32'h1);
    tick();
    rd_req = 1'b0;
    check("busy_idle", 32'(busy), 32'h0);
    check("busy_no_extra", 32'(mem_req), 32'h0);
    tick();
    check("busy_no_extra2", 32'(mem_req), 32'h0);

    // Reset in the middle of a read; late ack ignored
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    check("mid_rst_mdr", mdr_out, 32'h0);
    check("mid_rst_req", 32'(mem_req), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("mid_rst_nodone", 32'(done), 32'h0);
    check("mid_rst_mdr2", mdr_out, 32'h0);

    // Read that is never acknowledged
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    check("to_pre_busy", 32'(busy), 32'h1);
    check("to_pre_err", 32'(err), 32'h0);
    tick();
`ifdef MEM_IF_TIMEOUT_EN
    check("to_err", 32'(err), 32'h1);
    check("to_done", 32'(done), 32'h0);
    check("to_req", 32'(mem_req), 32'h0);
    check("to_busy", 32'(busy), 32'h0);
    check("to_mdr", mdr_out, 32'h0);
    tick();
    check("to_err_off", 32'(err), 32'h0);
`else
    check("hang_busy", 32'(busy), 32'h1);
    check("hang_req", 32'(mem_req), 32'h1);
    check("hang_err", 32'(err), 32'h0);
    for (int i = 0; i < 30; i++) tick();
    check("hang_busy_late", 32'(busy), 32'h1);
    check("hang_done", 32'(done), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_if_ctrl.md
Name: mem_if_ctrl

Overview:
- Memory interface stage that feeds the datapath bus: holds MAR and MDR and drives the MDR value onto the bus-mux MDR input.
- Runs a request/acknowledge handshake with the word-addressed RAM for reads and writes.
- The control sequencer issues rd_req/wr_req and waits for done before advancing to the next T-state.

Parameters:
ADDR_W, 9, MAR/memory address width (512 words)
DATA_W, 32, data word width
TIMEOUT_CYCLES, 16, cycles without mem_ack before abort (TIMEOUT_EN only)

Ports:
clk  input  1  system clock, all state changes on rising edge
clear_n  input  1  synchronous active-low reset
bus_in  input  DATA_W  datapath bus value (BusMuxOut)
mar_in  input  1  load MAR from bus_in[ADDR_W-1:0]
mdr_in  input  1  load MDR from bus_in
rd_req  input  1  start memory read at MAR into MDR
wr_req  input  1  start memory write of MDR to MAR
mem_rdata  input  DATA_W  RAM read data, valid when mem_ack=1
mem_ack  input  1  RAM acknowledge, one or more cycles after mem_req
mdr_out  output  DATA_W  MDR contents, to bus-mux MDR input
mar_q  output  ADDR_W  MAR contents
mem_req  output  1  RAM request, held until acknowledged
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  output  ADDR_W  equals mar_q
mem_wdata  output  DATA_W  equals mdr_out
busy  output  1  transaction in progress
done  output  1  one-cycle completion pulse
err  output  1  one-cycle abort pulse (0 when TIMEOUT_EN undefined)

Behaviour:
- Sampling: clear_n is sampled on the rising edge of clk.
- Reset: clear_n=0 on a rising edge sets MAR=0, MDR=0, state=IDLE, and mem_req, mem_we, busy, done, err=0. This holds mid-transaction: any outstanding mem_ack is then ignored.
- State machine: IDLE, RD_WAIT, WR_WAIT, DONE. All outputs are registered.
- IDLE:
  - mar_in and mdr_in load on the edge and are independent; both may be asserted in the same cycle.
  - rd_req=1 -> RD_WAIT, with mem_req=1 and mem_we=0 from the next cycle.
  - wr_req=1 -> WR_WAIT, with mem_req=1 and mem_we=1 from the next cycle.
  - rd_req and wr_req together: read wins; wr_req is dropped.
  - mar_in/mdr_in in the same cycle as a request: the load happens first, so the transaction uses the new value.
- RD_WAIT: on the edge where mem_ack=1, MDR <= mem_rdata, then -> DONE, with mem_req=0 on the next cycle.
- WR_WAIT: on the edge where mem_ack=1 -> DONE, with mem_req=0.
- DONE: done=1 for exactly one cycle, then -> IDLE. New requests are accepted from the following cycle.
- busy: 1 in RD_WAIT, WR_WAIT and DONE.
- While busy: mar_in, mdr_in, rd_req and wr_req are ignored. MAR and MDR stay frozen, so mem_addr and mem_wdata are stable under mem_req.
- mem_ack outside the WAIT states is ignored.
- Latency: request at edge 0 gives mem_req high after edge 0. An ack sampled at edge k gives done high and new MDR valid after edge k. Minimum read is 3 cycles from request to back in IDLE.

Optional Feature:
- Macro: MEM_IF_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to a WAIT state and increments each cycle without mem_ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: mem_req drops, err pulses for one cycle, done stays 0, MDR is unchanged, state -> IDLE.
  - An ack arriving in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; err is tied to 0; the block waits indefinitely.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (IDLE/RD_WAIT/WR_WAIT/DONE);
  - DATA_W and ADDR_W defaults;
  - the TIMEOUT_CYCLES default.
- One sub-module, mdr_reg, is the MDR with its MDMux: selects bus_in or mem_rdata, with load enable and synchronous active-low clear. The FSM and MAR stay in mem_if_ctrl.

Test Plan:
- Reset then load: clear_n=0 for 2 cycles, then mar_in with bus_in=0x0000_0055 -> mar_q=0x055, mdr_out=0, busy=0.
- Read with 2-cycle ack delay: MAR=0x055, rd_req pulse, RAM returns 0x1234_5678 -> mem_req high 3 cycles, mem_we=0, then done pulse with mdr_out=0x1234_5678.
- Write: mdr_in with bus_in=0xDEAD_BEEF, wr_req, immediate ack -> mem_we=1, mem_wdata=0xDEAD_BEEF, mem_addr=MAR, done 1 cycle.
- Busy-ignore and priority:
  - rd_req and wr_req together -> read only.
  - mdr_in with 0xFFFF_FFFF during RD_WAIT -> MDR is set by mem_rdata, not the bus.
  - A second rd_req while busy -> no extra transaction.
- Reset mid-read: clear_n=0 while in RD_WAIT with a later ack -> MDR=0, no done, mem_req=0.
- Timeout (MEM_IF_TIMEOUT_EN): rd_req, never ack -> err pulse after 16 wait cycles, done=0, MDR unchanged, busy=0 afterward. Without the macro: busy stays 1.
